tuning_word_editor: RTL

- Front-panel controller for the DDS tuning word. Three push-buttons edit a TW_WIDTH-bit phase increment one hex digit at a time.
- Drives the 4-bit count and blank control of the existing 7-segment hex converter, with the cursor digit blinking.
- Publishes the committed tuning word to the phase accumulator with a one-cycle update strobe.

---
 rtl/tuning_word_editor_pkg.sv | 38 +++
 rtl/tuning_word_editor_key_debouncer.sv | 50 +++++
 rtl/tuning_word_editor.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/tuning_word_editor_pkg.sv
// Shared definitions for the front-panel tuning word editor.
package tuning_word_editor_pkg;

  // Editor FSM states
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_EDIT   = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  // Edit action selected from the key events
  typedef enum logic [1:0] {
    ACT_NONE = 2'd0,
    ACT_SEL  = 2'd1,
    ACT_INC  = 2'd2,
    ACT_DEC  = 2'd3
  } action_t;

  // Key indices into the press-event vector
  localparam int KEY_SEL  = 0;
  localparam int KEY_INC  = 1;
  localparam int KEY_DEC  = 2;
  localparam int NUM_KEYS = 3;

  // Default timing for a 50 MHz clock
  localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
  localparam int DEFAULT_BLINK_CYCLES    = 12500000;

  // Apply an edit action to one hex digit; wraps within the nibble, no carry/borrow
  function automatic logic [3:0] nibble_step(input logic [3:0] n, input action_t act);
    logic [3:0] r;
    case (act)
      ACT_INC: r = n + 4'd1;
      ACT_DEC: r = n - 4'd1;
      default: r = n;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/tuning_word_editor_key_debouncer.sv
// Push-button conditioner: 2-FF synchronizer, level debouncer and press pulse.
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic key,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_r;
  logic             sync2_r;
  logic             level_r;
  logic [CNT_W-1:0] cnt_r;

  // Bring the asynchronous button level into the clock domain (idle = released = 1)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= key;
      sync2_r <= sync1_r;
    end
  end

  // Accept a new level after DEBOUNCE_CYCLES consecutive differing samples; pulse on press
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level_r <= 1'b1;
      cnt_r   <= '0;
      press   <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sync2_r == level_r) begin
        cnt_r <= '0;
      end else if (cnt_r == CNT_LAST) begin
        level_r <= sync2_r;
        cnt_r   <= '0;
        press   <= ~sync2_r;
      end else begin
        cnt_r <= cnt_r + 1'b1;
      end
    end
  end

endmodule

// File: rtl/tuning_word_editor.sv
// Front-panel editor for the DDS tuning word: edits one hex digit at a time,
// drives the 7-segment converter with a blinking cursor digit and publishes
// committed words with a one-cycle update strobe.
module tuning_word_editor
  import tuning_word_editor_pkg::*;
#(
  parameter int TW_WIDTH        = 32,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int BLINK_CYCLES    = DEFAULT_BLINK_CYCLES
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            key_inc,
  input  logic                            key_dec,
  input  logic                            key_sel,
  output logic [TW_WIDTH-1:0]             tuning_word,
  output logic                            tw_update,
  output logic [$clog2(TW_WIDTH/4)-1:0]   cursor,
  output logic [3:0]                      disp_count,
  output logic                            disp_on
);

  localparam int NUM_DIGITS = TW_WIDTH / 4;
  localparam int CUR_W      = $clog2(NUM_DIGITS);
  localparam logic [CUR_W-1:0] CUR_LAST = CUR_W'(NUM_DIGITS - 1);
  localparam int BLINK_W    = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);

  logic [NUM_KEYS-1:0] press;
  logic [1:0]          state_r;
  action_t             action_r;
  action_t             act_s;
  logic [TW_WIDTH-1:0] shadow_r;
  logic [TW_WIDTH-1:0] shadow_next_s;
  logic [CUR_W-1:0]    cursor_next_s;
  logic [3:0]          cur_nib_s;
  logic [BLINK_W-1:0]  blink_r;

  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_sel (
    .clk(clk), .reset(reset), .key(key_sel), .press(press[KEY_SEL])
  );
  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_inc (
    .clk(clk), .reset(reset), .key(key_inc), .press(press[KEY_INC])
  );
  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_dec (
    .clk(clk), .reset(reset), .key(key_dec), .press(press[KEY_DEC])
  );

  // Pick a single action per cycle: sel beats inc beats dec, losers are dropped
  always_comb begin
    act_s = ACT_NONE;
    if (press[KEY_SEL]) begin
      act_s = ACT_SEL;
    end else if (press[KEY_INC]) begin
      act_s = ACT_INC;
    end else if (press[KEY_DEC]) begin
      act_s = ACT_DEC;
    end else begin
      act_s = ACT_NONE;
    end
  end

  // Next shadow word and cursor for the latched action
  always_comb begin
    cur_nib_s     = 4'(shadow_r >> {cursor, 2'b00});
    shadow_next_s = shadow_r;
    shadow_next_s[{cursor, 2'b00} +: 4] = nibble_step(cur_nib_s, action_r);
    cursor_next_s = cursor;
    if (action_r == ACT_SEL) begin
      cursor_next_s = (cursor == CUR_LAST) ? '0 : cursor + 1'b1;
    end else begin
      cursor_next_s = cursor;
    end
  end

  // Editor FSM: latch action, apply it to shadow/cursor, publish inc/dec results
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      action_r    <= ACT_NONE;
      shadow_r    <= '0;
      cursor      <= '0;
      tuning_word <= '0;
      tw_update   <= 1'b0;
    end else begin
      tw_update <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (act_s != ACT_NONE) begin
            action_r <= act_s;
            state_r  <= ST_EDIT;
          end else begin
            state_r  <= ST_IDLE;
          end
        end
        ST_EDIT: begin
          shadow_r <= shadow_next_s;
          cursor   <= cursor_next_s;
          if ((action_r == ACT_INC) || (action_r == ACT_DEC)) begin
            tuning_word <= shadow_next_s;
            tw_update   <= 1'b1;
          end else begin
            tuning_word <= tuning_word;
          end
          state_r <= ST_COMMIT;
        end
        ST_COMMIT: begin
          action_r <= ACT_NONE;
          state_r  <= ST_IDLE;
        end
        default: begin
          action_r <= ACT_NONE;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

  // Display digit follows the shadow nibble under the cursor, one cycle behind
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      disp_count <= 4'd0;
    end else begin
      disp_count <= cur_nib_s;
    end
  end

  // Cursor blink: toggle on counter wrap, restart lit on any key press
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blink_r <= '0;
      disp_on <= 1'b1;
    end else if (|press) begin
      blink_r <= '0;
      disp_on <= 1'b1;
    end else if (blink_r == BLINK_LAST) begin
      blink_r <= '0;
      disp_on <= ~disp_on;
    end else begin
      blink_r <= blink_r + 1'b1;
    end
  end

endmodule
